mux_scanner: RTL and testbench

MUX_SCANNER -- requirements
Module: mux_scanner

---
 rtl/mux_scanner.sv | 112 +++++++++++
 tb/tb_mux_scanner.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_scanner.sv
// mux_scanner: steps a downstream 4:1 mux through channels 0..3. For each
// channel it waits a programmable settle time and then samples the mux
// output. The four samples form one word, which is held until it is consumed.
module mux_scanner #(
  parameter int DWELL_W = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [DWELL_W-1:0] dwell,
  output logic [1:0]         sel,
  input  logic               y_in,
  output logic [3:0]         word,
  output logic               valid,
  input  logic               ready,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t             state;
  logic [DWELL_W-1:0] cnt;
  logic [DWELL_W-1:0] dwell_q;
  logic [3:0]         shadow;

  // Scan sequencer. All outputs are registered here, and busy is updated
  // together with state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sel     <= 2'd0;
      cnt     <= '0;
      dwell_q <= '0;
      shadow  <= 4'd0;
      word    <= 4'd0;
      valid   <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          sel <= 2'd0;
          if (start) begin
            // The dwell value is captured once here. Later changes to the
            // dwell input do not affect the scan in progress.
            cnt     <= dwell;
            dwell_q <= dwell;
            shadow  <= 4'd0;
            state   <= SETTLE;
            busy    <= 1'b1;
          end
        end

        SETTLE: begin
          // Count down to zero and stop there, so the counter never wraps.
          // The zero cycle adds one, giving dwell+1 settle cycles.
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state <= SAMPLE;
          end
        end

        SAMPLE: begin
          shadow[sel] <= y_in;
          if (sel != 2'd3) begin
            sel   <= sel + 2'd1;
            cnt   <= dwell_q;
            state <= SETTLE;
          end else begin
            // Channel 3 is taken straight from y_in. Its shadow bit is only
            // written on this same edge.
            word  <= {y_in, shadow[2:0]};
            valid <= 1'b1;
            state <= HOLD;
          end
        end

        HOLD: begin
          if (ready) begin
            valid <= 1'b0;
            sel   <= 2'd0;
            if (start) begin
              // Back-to-back: the next scan starts on the same edge that
              // consumes the word.
              cnt     <= dwell;
              dwell_q <= dwell;
              shadow  <= 4'd0;
              state   <= SETTLE;
              busy    <= 1'b1;
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end

        default: begin
          state <= IDLE;
          sel   <= 2'd0;
          valid <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mux_scanner.sv
// Directed bench for mux_scanner. The downstream 4:1 mux is modelled as
// y_in = d[sel].
module tb_mux_scanner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] dwell;
  logic [1:0] sel;
  logic       y_in;
  logic [3:0] word;
  logic       valid;
  logic       ready;
  logic       busy;
  logic [3:0] d;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  assign y_in = d[sel];

  mux_scanner #(.DWELL_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .dwell (dwell),
    .sel   (sel),
    .y_in  (y_in),
    .word  (word),
    .valid (valid),
    .ready (ready),
    .busy  (busy)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present start for exactly one edge. Afterwards the bench sits just after
  // edge 0, the edge that accepted start.
  task automatic start_scan(input int dw);
    start = 1'b1;
    dwell = 4'(dw);
    tick();
    start = 1'b0;
  endtask

  // Count edges until valid is seen. The wait is bounded so it cannot hang.
  task automatic wait_valid(output int n);
    n = 0;
    while (!valid && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic consume();
    ready = 1'b1;
    tick();
    ready = 1'b0;
  endtask

  int n;
  int exp_sel[8] = '{0, 0, 1, 1, 2, 2, 3, 3};

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    dwell = 4'd0;
    ready = 1'b0;
    d     = 4'd0;
    #12;
    chk("rst_valid", int'(valid), 0);
    chk("rst_busy",  int'(busy),  0);
    chk("rst_sel",   int'(sel),   0);
    chk("rst_word",  int'(word),  0);
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle_busy", int'(busy), 0);
    chk("idle_sel",  int'(sel),  0);

    // dwell=0, d=1010: check the sel sequence and that valid arrives at edge 8.
    d = 4'b1010;
    start_scan(0);
    chk("s31_busy", int'(busy), 1);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("s31_sel%0d", k), int'(sel), exp_sel[k]);
      if (k == 7) begin
        chk("s31_nopartial_valid", int'(valid), 0);
        chk("s31_nopartial_word",  int'(word),  0);
      end
      tick();
    end
    chk("s31_valid", int'(valid), 1);
    chk("s31_word",  int'(word),  int'(4'b1010));
    chk("s31_sel_end", int'(sel), 3);
    consume();
    chk("s31_rel_valid", int'(valid), 0);
    chk("s31_rel_busy",  int'(busy),  0);
    chk("s31_rel_sel",   int'(sel),   0);

    // dwell=3, d=0110: the word must hold while ready stays low.
    d = 4'b0110;
    start_scan(3);
    wait_valid(n);
    chk("s32_latency", n, 20);
    chk("s32_word", int'(word), int'(4'b0110));
    for (int k = 0; k < 10; k++) begin
      start = k[0];
      tick();
      chk("s32_hold_valid", int'(valid), 1);
      chk("s32_hold_word",  int'(word),  int'(4'b0110));
      chk("s32_hold_busy",  int'(busy),  1);
    end
    start = 1'b0;
    consume();
    chk("s32_idle_valid", int'(valid), 0);
    chk("s32_idle_busy",  int'(busy),  0);

    // Back-to-back scans: ready and start are asserted on the same edge.
    d = 4'b1001;
    start_scan(1);
    wait_valid(n);
    chk("s33_lat1", n, 12);
    chk("s33_word1", int'(word), int'(4'b1001));
    d     = 4'b0011;
    ready = 1'b1;
    start = 1'b1;
    dwell = 4'd1;
    tick();
    ready = 1'b0;
    start = 1'b0;
    chk("s33_valid_drop", int'(valid), 0);
    chk("s33_sel0", int'(sel), 0);
    chk("s33_busy", int'(busy), 1);
    chk("s33_word_kept", int'(word), int'(4'b1001));
    wait_valid(n);
    chk("s33_lat2", n, 12);
    chk("s33_word2", int'(word), int'(4'b0011));
    consume();

    // Changing dwell mid-scan must not affect the scan in progress.
    d = 4'b0101;
    start_scan(2);
    tick();
    tick();
    tick();
    dwell = 4'd7;
    wait_valid(n);
    chk("s34_latency", n + 3, 16);
    chk("s34_word", int'(word), int'(4'b0101));
    consume();

    // Assert reset asynchronously while sel=2.
    d = 4'b1111;
    start_scan(1);
    n = 0;
    while (sel != 2'd2 && n < 50) begin
      tick();
      n++;
    end
    chk("s35_reached_sel2", int'(sel), 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s35_async_sel",   int'(sel),   0);
    chk("s35_async_busy",  int'(busy),  0);
    chk("s35_async_valid", int'(valid), 0);
    chk("s35_async_word",  int'(word),  0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("s35_post_busy",  int'(busy),  0);
    chk("s35_post_valid", int'(valid), 0);
    chk("s35_post_word",  int'(word),  0);
    start_scan(1);
    wait_valid(n);
    chk("s35_latency", n, 12);
    chk("s35_word", int'(word), int'(4'b1111));
    consume();

    // Maximum dwell (15): the settle counter must not wrap.
    d = 4'b1100;
    start_scan(15);
    wait_valid(n);
    chk("s36_latency", n, 68);
    chk("s36_word", int'(word), int'(4'b1100));
    consume();
    chk("s36_idle", int'(busy), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
